// File: rtl/i2c_txn_sequencer_pkg.sv
// Shared types and constants for the I2C target transaction sequencer:
// FSM state encoding, default back-end addresses and R/W direction values.
package i2c_txn_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  localparam logic [6:0] DEF_ADDR0 = 7'h55;
  localparam logic [6:0] DEF_ADDR1 = 7'h2A;
  localparam logic [6:0] DEF_ADDR2 = 7'h3F;
  localparam logic [6:0] DEF_ADDR3 = 7'h21;

  // Value of the R/W bit for each direction (reused by pad wrappers).
  localparam logic READ_MASK  = 1'b1;
  localparam logic WRITE_MASK = 1'b0;

  // Returns {hit, index}; the lowest index wins when addresses alias.
  function automatic logic [2:0] addr_lookup(input logic [6:0] a, input logic [6:0] a0,
                                             input logic [6:0] a1, input logic [6:0] a2,
                                             input logic [6:0] a3);
    logic [2:0] r;
    r = 3'b000;
    if (a == a0)      r = 3'b100;
    else if (a == a1) r = 3'b101;
    else if (a == a2) r = 3'b110;
    else if (a == a3) r = 3'b111;
    return r;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer_line_monitor.sv
// Two-flop synchronisers for SCL/SDA and registered edge/START/STOP pulses.
// Pin-to-pulse latency is three clocks; all flops idle high.
module i2c_txn_sequencer_line_monitor (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta  <= 1'b1;
      scl_sync  <= 1'b1;
      scl_prev  <= 1'b1;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_meta  <= scl_in;
      scl_sync  <= scl_meta;
      scl_prev  <= scl_sync;
      sda_meta  <= sda_in;
      sda_sync  <= sda_meta;
      sda_prev  <= sda_sync;
      scl_rise  <= scl_sync & ~scl_prev;
      scl_fall  <= ~scl_sync & scl_prev;
      start_det <= scl_sync & scl_prev & ~sda_sync & sda_prev;
      stop_det  <= scl_sync & scl_prev & sda_sync & ~sda_prev;
    end
  end

  // sda_prev lines up with the registered pulses one cycle later.
  assign sda = sda_prev;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// I2C target framing FSM sharing the bus between four byte-wide back-ends.
// Optional feature macro: I2C_CLOCK_STRETCH_EN (hold SCL low while a read byte is missing).
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter logic [6:0] ADDR0 = DEF_ADDR0,
  parameter logic [6:0] ADDR1 = DEF_ADDR1,
  parameter logic [6:0] ADDR2 = DEF_ADDR2,
  parameter logic [6:0] ADDR3 = DEF_ADDR3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [1:0] periph_sel,
  output logic       txn_active,
  output logic       is_read,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  output logic [3:0] byte_count,
  output logic       rd_underflow,
  output state_t     dbg_state
);

  // Read handshake: a byte moves when rd_req & rd_valid are both high on a
  // clock edge; rd_req drops on that same edge.

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_txn_sequencer_line_monitor u_mon (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n, byte_count_n;
  logic [7:0] shift, shift_n, rd_buf, rd_buf_n, wr_data_n;
  logic       buf_full, buf_full_n, slot, slot_n, do_load;
  logic       sda_oe_n, txn_active_n, is_read_n, wr_valid_n, rd_req_n;
  logic [1:0] periph_sel_n;
  logic [2:0] lookup;
  logic       accept, avail;
  logic [7:0] next_byte;

  assign lookup    = addr_lookup(shift[6:0], ADDR0, ADDR1, ADDR2, ADDR3);
  assign accept    = rd_req & rd_valid;
  assign avail     = buf_full | accept;
  assign next_byte = buf_full ? rd_buf : rd_data;
  assign dbg_state = state;

`ifdef I2C_CLOCK_STRETCH_EN
  logic       stretching, stretching_n, scl_hold, scl_hold_n;
  logic [1:0] rel_cnt, rel_cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      stretching <= 1'b0;
      scl_hold   <= 1'b0;
      rel_cnt    <= 2'd0;
    end else begin
      stretching <= stretching_n;
      scl_hold   <= scl_hold_n;
      rel_cnt    <= rel_cnt_n;
    end
  end

  assign scl_oe       = scl_hold;
  assign rd_underflow = 1'b0;
`else
  logic underflow_q, underflow_n;

  always_ff @(posedge clk) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= underflow_n;
  end

  assign scl_oe       = 1'b0;
  assign rd_underflow = underflow_q;
`endif

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    rd_buf_n     = rd_buf;
    buf_full_n   = buf_full;
    slot_n       = slot;
    sda_oe_n     = sda_oe;
    periph_sel_n = periph_sel;
    txn_active_n = txn_active;
    is_read_n    = is_read;
    wr_valid_n   = 1'b0;
    wr_data_n    = wr_data;
    rd_req_n     = rd_req;
    byte_count_n = byte_count;
    do_load      = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
    stretching_n = stretching;
    scl_hold_n   = scl_hold;
    rel_cnt_n    = rel_cnt;
`else
    underflow_n  = 1'b0;
`endif
    // Bus conditions override everything, including a same-cycle rd_valid.
    if (start_det || stop_det) begin
      state_n      = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_n    = 4'd0;
      sda_oe_n     = 1'b0;
      rd_req_n     = 1'b0;
      buf_full_n   = 1'b0;
      txn_active_n = 1'b0;
      is_read_n    = 1'b0;
      slot_n       = 1'b0;
      if (start_det) byte_count_n = 4'd0;
`ifdef I2C_CLOCK_STRETCH_EN
      stretching_n = 1'b0;
      scl_hold_n   = 1'b0;
      rel_cnt_n    = 2'd0;
`endif
    end else begin
      if (accept) begin
        rd_buf_n   = rd_data;
        buf_full_n = 1'b1;
        rd_req_n   = 1'b0;
      end
`ifdef I2C_CLOCK_STRETCH_EN
      if (rel_cnt != 2'd0) begin
        rel_cnt_n = rel_cnt - 2'd1;
        if (rel_cnt == 2'd1) scl_hold_n = 1'b0;
      end
      // Late byte while SCL is held: drive bit 7 now, release SCL two clocks later.
      if (stretching && accept) begin
        shift_n      = rd_data;
        sda_oe_n     = ~rd_data[7];
        buf_full_n   = 1'b0;
        stretching_n = 1'b0;
        rel_cnt_n    = 2'd2;
      end
`endif
      case (state)
        ST_ADDR: if (scl_rise) begin
          shift_n   = {shift[6:0], sda};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (lookup[2]) begin
              state_n      = ST_ADDR_ACK;
              slot_n       = 1'b0;
              periph_sel_n = lookup[1:0];
              is_read_n    = (sda == READ_MASK);
              txn_active_n = 1'b1;
              rd_req_n     = (sda == READ_MASK);
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
          if (!slot) begin
            sda_oe_n = 1'b1;
            slot_n   = 1'b1;
          end else if (is_read) begin
            do_load = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            state_n   = ST_WR_BYTE;
            bit_cnt_n = 4'd0;
          end
        end
        ST_WR_BYTE: if (scl_rise) begin
          shift_n   = {shift[6:0], sda};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            wr_data_n    = {shift[6:0], sda};
            wr_valid_n   = 1'b1;
            byte_count_n = sat_inc(byte_count);
            state_n      = ST_WR_ACK;
            slot_n       = 1'b0;
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n     = 1'b0;
              state_n      = ST_RD_ACK;
              byte_count_n = sat_inc(byte_count);
            end else begin
              shift_n  = {shift[6:0], shift[7]};
              sda_oe_n = ~shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda) begin
              state_n    = ST_WAIT_STOP;
              rd_req_n   = 1'b0;
              buf_full_n = 1'b0;
            end else begin
              rd_req_n = ~buf_full_n;
            end
          end else if (scl_fall) begin
            do_load = 1'b1;
          end
        end
        default: ;
      endcase
      // End of an ACK slot in a read: present bit 7 of the next byte.
      if (do_load) begin
        state_n   = ST_RD_BYTE;
        bit_cnt_n = 4'd0;
        if (avail) begin
          shift_n    = next_byte;
          sda_oe_n   = ~next_byte[7];
          buf_full_n = 1'b0;
        end else begin
          sda_oe_n = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
          scl_hold_n   = 1'b1;
          stretching_n = 1'b1;
`else
          shift_n     = 8'hFF;
          underflow_n = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      rd_buf     <= 8'h00;
      buf_full   <= 1'b0;
      slot       <= 1'b0;
      sda_oe     <= 1'b0;
      periph_sel <= 2'd0;
      txn_active <= 1'b0;
      is_read    <= 1'b0;
      wr_valid   <= 1'b0;
      wr_data    <= 8'h00;
      rd_req     <= 1'b0;
      byte_count <= 4'd0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      rd_buf     <= rd_buf_n;
      buf_full   <= buf_full_n;
      slot       <= slot_n;
      sda_oe     <= sda_oe_n;
      periph_sel <= periph_sel_n;
      txn_active <= txn_active_n;
      is_read    <= is_read_n;
      wr_valid   <= wr_valid_n;
      wr_data    <= wr_data_n;
      rd_req     <= rd_req_n;
      byte_count <= byte_count_n;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: bit-banged I2C controller, a byte-source back-end
// and a scoreboard of expected written/read bytes.
module tb_i2c_txn_sequencer;
  import i2c_txn_sequencer_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in, scl_line, sda_line;
  logic       sda_oe, scl_oe, txn_active, is_read, wr_valid, rd_req, rd_underflow;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data = 8'h00, wr_data;
  logic [1:0] periph_sel;
  logic [3:0] byte_count;
  state_t     dbg_state;

  // open-drain wired-AND bus
  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;
  assign scl_in   = scl_line;
  assign sda_in   = sda_line;

  i2c_txn_sequencer dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .periph_sel(periph_sel),
    .txn_active(txn_active), .is_read(is_read), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .byte_count(byte_count), .rd_underflow(rd_underflow), .dbg_state(dbg_state)
  );

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  int         hold_cycles = 0;
  int         wr_pulses = 0, uf_pulses = 0, rd_req_bad = 0;
  logic       stretch_seen = 1'b0;
  logic [1:0] exp_sel = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // back-end: offers src_q[0], withheld while hold_cycles > 0 and rd_req is high
  initial begin
    logic fire;
    fire = 1'b0;
    forever begin
      @(negedge clk);
      if (fire && src_q.size() != 0) void'(src_q.pop_front());
      if (hold_cycles > 0 && rd_req) hold_cycles--;
      rd_valid = (src_q.size() != 0) && (hold_cycles == 0);
      rd_data  = rd_valid ? src_q[0] : 8'h00;
      fire     = rd_req & rd_valid;
    end
  end

  // scoreboard for written bytes and protocol monitors
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid) begin
        wr_pulses++;
        check("wr_sel", {30'd0, periph_sel}, {30'd0, exp_sel});
        if (exp_q.size() != 0) check("wr_data", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
      end
      if (rd_underflow) uf_pulses++;
      if (scl_oe) stretch_seen = 1'b1;
      if (rd_req && (dbg_state == ST_IDLE || !is_read)) rd_req_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared expected done", n_cmp);
    $fatal(1);
  end

  // driver tasks (controller side)
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int n;
    n = 0;
    scl_m = 1'b1;
    while (!scl_line && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!scl_line) check("scl_release_timeout", {31'd0, scl_line}, 32'd1);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;
    wait_clk(5);
    scl_high();
    wait_clk(5);
    s = sda_line;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic send_start();
    if (!scl_m) begin
      sda_m = 1'b1;
      wait_clk(5);
      scl_high();
      wait_clk(5);
    end
    sda_m = 1'b0;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic send_stop();
    sda_m = 1'b0;
    wait_clk(5);
    scl_high();
    wait_clk(5);
    sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_and_check(input string tag, input logic m_ack);
    logic       s;
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(~m_ack, s);
    if (exp_q.size() != 0) check(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
    else check({tag, "_no_expected"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic ack, s;
    int   wp0, uf0;

    reset = 1'b1;
    wait_clk(5);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_txn_active", {31'd0, txn_active}, 32'd0);
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_byte_count", {28'd0, byte_count}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    wait_clk(5);

    // 1: read 0x55, back-end 0 supplies 0xAA, NACK
    src_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    send_start();
    write_byte(8'hAB, ack);
    check("t1_addr_ack", {31'd0, ack}, 32'd1);
    check("t1_sel", {30'd0, periph_sel}, 32'd0);
    check("t1_is_read", {31'd0, is_read}, 32'd1);
    read_and_check("t1_rd_byte", 1'b0);
    send_stop();
    check("t1_byte_count", {28'd0, byte_count}, 32'd1);
    check("t1_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("t1_txn_active", {31'd0, txn_active}, 32'd0);

    // 2: write 0x2A, two data bytes
    wp0 = wr_pulses; exp_sel = 2'd1;
    send_start();
    write_byte(8'h54, ack);
    check("t2_addr_ack", {31'd0, ack}, 32'd1);
    check("t2_txn_active", {31'd0, txn_active}, 32'd1);
    exp_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    check("t2_ack1", {31'd0, ack}, 32'd1);
    exp_q.push_back(8'hC3);
    write_byte(8'hC3, ack);
    check("t2_ack2", {31'd0, ack}, 32'd1);
    send_stop();
    check("t2_wr_pulses", wr_pulses - wp0, 32'd2);
    check("t2_byte_count", {28'd0, byte_count}, 32'd2);
    check("t2_wr_data_hold", {24'd0, wr_data}, 32'hC3);

    // 3: unmatched address 0x10
    wp0 = wr_pulses;
    send_start();
    write_byte(8'h20, ack);
    check("t3_addr_nack", {31'd0, ack}, 32'd0);
    check("t3_txn_active", {31'd0, txn_active}, 32'd0);
    write_byte(8'h11, ack);
    check("t3_data_nack", {31'd0, ack}, 32'd0);
    send_stop();
    check("t3_wr_pulses", wr_pulses - wp0, 32'd0);
    check("t3_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // 4: read 0x3F with the byte withheld 40 clk
    uf0 = uf_pulses; stretch_seen = 1'b0; hold_cycles = 40;
    src_q.push_back(8'h96);
`ifdef I2C_CLOCK_STRETCH_EN
    exp_q.push_back(8'h96);
`else
    exp_q.push_back(8'hFF);
`endif
    send_start();
    write_byte(8'h7F, ack);
    check("t4_addr_ack", {31'd0, ack}, 32'd1);
    check("t4_sel", {30'd0, periph_sel}, 32'd2);
    read_and_check("t4_rd_byte", 1'b0);
    send_stop();
`ifdef I2C_CLOCK_STRETCH_EN
    check("t4_stretched", {31'd0, stretch_seen}, 32'd1);
    check("t4_underflows", uf_pulses - uf0, 32'd0);
`else
    check("t4_stretched", {31'd0, stretch_seen}, 32'd0);
    check("t4_underflows", uf_pulses - uf0, 32'd1);
`endif
    check("t4_late_byte_taken", src_q.size(), 32'd0);
    check("t4_byte_count", {28'd0, byte_count}, 32'd1);

    // 5a: STOP after four bits of a write byte
    wp0 = wr_pulses; exp_sel = 2'd0;
    send_start();
    write_byte(8'hAA, ack);
    check("t5a_addr_ack", {31'd0, ack}, 32'd1);
    clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
    send_stop();
    check("t5a_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("t5a_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("t5a_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("t5a_wr_pulses", wr_pulses - wp0, 32'd0);

    // 5b: reset while transmitting 0x00
    src_q.push_back(8'h00);
    send_start();
    write_byte(8'hAB, ack);
    check("t5b_addr_ack", {31'd0, ack}, 32'd1);
    clock_bit(1'b1, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
    check("t5b_driving", {31'd0, sda_oe}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t5b_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("t5b_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("t5b_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("t5b_rd_req", {31'd0, rd_req}, 32'd0);
    reset = 1'b0;
    sda_m = 1'b1;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(10);
    src_q.delete();

    // 6: write 0x55, repeated START, read 0x2A
    exp_sel = 2'd0;
    send_start();
    write_byte(8'hAA, ack);
    check("t6_wr_addr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back(8'h12);
    write_byte(8'h12, ack);
    check("t6_wr_ack", {31'd0, ack}, 32'd1);
    check("t6_count_before", {28'd0, byte_count}, 32'd1);
    check("t6_sel_before", {30'd0, periph_sel}, 32'd0);
    src_q.push_back(8'h5C); exp_q.push_back(8'h5C);
    send_start();
    write_byte(8'h55, ack);
    check("t6_rd_addr_ack", {31'd0, ack}, 32'd1);
    check("t6_sel_after", {30'd0, periph_sel}, 32'd1);
    check("t6_count_restart", {28'd0, byte_count}, 32'd0);
    read_and_check("t6_rd_byte", 1'b0);
    send_stop();
    check("t6_count_after", {28'd0, byte_count}, 32'd1);

    // final report
    check("rd_req_outside_read", rd_req_bad, 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
